// File: rtl/taus_urng_pkg.sv
`default_nettype none
// ============================================================================
// Module      : taus_urng_pkg
// Description : Shared constants and types for the dual taus88 uniform
//               generator: step masks and shift amounts, minimum legal seed
//               words, default seeds, and the WARMUP/RUN state type.
// Revision    : 1.0 - initial release
// ============================================================================
package taus_urng_pkg;

  // taus88 component 0: ((s & MASK) << SHL) ^ (((s << MIX) ^ s) >> SHR)
  localparam logic [31:0] c_s0_mask = 32'hFFFF_FFFE;
  localparam int unsigned c_s0_shl  = 12;
  localparam int unsigned c_s0_mix  = 13;
  localparam int unsigned c_s0_shr  = 19;
  // component 1
  localparam logic [31:0] c_s1_mask = 32'hFFFF_FFF8;
  localparam int unsigned c_s1_shl  = 4;
  localparam int unsigned c_s1_mix  = 2;
  localparam int unsigned c_s1_shr  = 25;
  // component 2
  localparam logic [31:0] c_s2_mask = 32'hFFFF_FFF0;
  localparam int unsigned c_s2_shl  = 17;
  localparam int unsigned c_s2_mix  = 3;
  localparam int unsigned c_s2_shr  = 11;

  // Below these values a component degenerates (its masked bits are all
  // zero), so committed seeds smaller than this are replaced by defaults.
  localparam logic [31:0] c_min_s0 = 32'd2;
  localparam logic [31:0] c_min_s1 = 32'd8;
  localparam logic [31:0] c_min_s2 = 32'd16;

  localparam logic [31:0] c_def_a0 = 32'h1234_5678;
  localparam logic [31:0] c_def_a1 = 32'h9ABC_DEF0;
  localparam logic [31:0] c_def_a2 = 32'h0F1E_2D3C;
  localparam logic [31:0] c_def_b0 = 32'hCAFE_BABE;
  localparam logic [31:0] c_def_b1 = 32'hDEAD_BEEF;
  localparam logic [31:0] c_def_b2 = 32'h7654_3210;

  typedef enum logic [0:0] {
    ST_WARMUP = 1'b0,
    ST_RUN    = 1'b1
  } state_t;

  // Seed words are stored A0,A1,A2,B0,B1,B2; index mod 3 selects the component.
  function automatic logic [31:0] seed_min(input int unsigned idx);
    case (idx % 3)
      0:       return c_min_s0;
      1:       return c_min_s1;
      default: return c_min_s2;
    endcase
  endfunction

  function automatic logic [31:0] fix_seed(input logic [31:0] word,
                                           input logic [31:0] min_val,
                                           input logic [31:0] def_val);
    return (word < min_val) ? def_val : word;
  endfunction

endpackage
`default_nettype wire

// File: rtl/taus_urng_if.sv
`default_nettype none
// ============================================================================
// Module      : taus_urng_if
// Description : Control/data bundle of the uniform generator.
//   en          advance request
//   seed_we     write seed_data into shadow word seed_addr (0..5 = A0..B2)
//   seed_addr   shadow index, 6..7 ignored
//   seed_data   seed word
//   seed_commit load live state from shadow and restart warm-up
//   u0, u1      registered uniform samples (48 / 16 bits)
//   valid       u0/u1 fresh this cycle
//   busy        warm-up in progress
// Revision    : 1.0 - initial release
// ============================================================================
interface taus_urng_if;
  logic        en;
  logic        seed_we;
  logic [2:0]  seed_addr;
  logic [31:0] seed_data;
  logic        seed_commit;
  logic [47:0] u0;
  logic [15:0] u1;
  logic        valid;
  logic        busy;

  modport master (
    output en, seed_we, seed_addr, seed_data, seed_commit,
    input  u0, u1, valid, busy
  );

  modport slave (
    input  en, seed_we, seed_addr, seed_data, seed_commit,
    output u0, u1, valid, busy
  );
endinterface
`default_nettype wire

// File: rtl/taus_urng_step.sv
`default_nettype none
// ============================================================================
// Module      : taus88_step
// Description : One combinational taus88 step. Takes the three 32-bit
//               component states and returns the next states and the
//               generator output (XOR of the next states).
//   i_s0..i_s2  current component states
//   o_s0..o_s2  next component states
//   o_rnd       output word computed from the post-update state
// Revision    : 1.0 - initial release
// ============================================================================
module taus88_step
  import taus_urng_pkg::*;
(
  input  logic [31:0] i_s0,
  input  logic [31:0] i_s1,
  input  logic [31:0] i_s2,
  output logic [31:0] o_s0,
  output logic [31:0] o_s1,
  output logic [31:0] o_s2,
  output logic [31:0] o_rnd
);

  logic [31:0] w_n0;
  logic [31:0] w_n1;
  logic [31:0] w_n2;

  assign w_n0 = ((i_s0 & c_s0_mask) << c_s0_shl) ^ (((i_s0 << c_s0_mix) ^ i_s0) >> c_s0_shr);
  assign w_n1 = ((i_s1 & c_s1_mask) << c_s1_shl) ^ (((i_s1 << c_s1_mix) ^ i_s1) >> c_s1_shr);
  assign w_n2 = ((i_s2 & c_s2_mask) << c_s2_shl) ^ (((i_s2 << c_s2_mix) ^ i_s2) >> c_s2_shr);

  assign o_s0  = w_n0;
  assign o_s1  = w_n1;
  assign o_s2  = w_n2;
  assign o_rnd = w_n0 ^ w_n1 ^ w_n2;

endmodule
`default_nettype wire

// File: rtl/taus_urng.sv
`default_nettype none
// ============================================================================
// Module      : taus_urng
// Description : Dual taus88 uniform random source for a Box-Muller stage.
//               Generator A supplies u0[47:16]; generator B supplies
//               u0[15:0] (its upper half) and u1 (its lower half).
//   clk     rising-edge clock
//   reset   asynchronous active-low reset (release synchronised internally)
//   bus     taus_urng_if.slave: en, seed_we/addr/data, seed_commit,
//           u0, u1, valid, busy
// Revision    : 1.0 - initial release
// ============================================================================
module taus_urng
  import taus_urng_pkg::*;
#(
  parameter int unsigned WARMUP_CYCLES = 16,
  parameter logic [31:0] SEED_A0 = c_def_a0,
  parameter logic [31:0] SEED_A1 = c_def_a1,
  parameter logic [31:0] SEED_A2 = c_def_a2,
  parameter logic [31:0] SEED_B0 = c_def_b0,
  parameter logic [31:0] SEED_B1 = c_def_b1,
  parameter logic [31:0] SEED_B2 = c_def_b2
) (
  input  logic        clk,
  input  logic        reset,
  taus_urng_if.slave  bus
);

  localparam logic [31:0] c_seed_def [6] = '{SEED_A0, SEED_A1, SEED_A2,
                                             SEED_B0, SEED_B1, SEED_B2};
  localparam bit          c_no_warmup = (WARMUP_CYCLES == 0);
  // Counter value on the last warm-up step (only meaningful when warm-up is on).
  localparam logic [7:0]  c_warm_last = c_no_warmup ? 8'd0 : 8'(WARMUP_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Reset: asserts asynchronously, releases after two clean rising edges.
  // ---------------------------------------------------------------------------
  logic [1:0] r_rst_sync;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign rst_n = r_rst_sync[1];

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_next;
  logic [31:0] r_live [6];
  logic [31:0] w_live_next [6];
  logic [31:0] r_shadow [6];
  logic [31:0] w_shadow_next [6];
  logic [31:0] w_gen_next [6];
  logic [31:0] w_rnd_a;
  logic [31:0] w_rnd_b;
  logic [47:0] r_u0;
  logic [47:0] w_u0_next;
  logic [15:0] r_u1;
  logic [15:0] w_u1_next;
  logic        r_valid;
  logic        w_valid_next;

  taus88_step u_step_a (
    .i_s0  (r_live[0]),
    .i_s1  (r_live[1]),
    .i_s2  (r_live[2]),
    .o_s0  (w_gen_next[0]),
    .o_s1  (w_gen_next[1]),
    .o_s2  (w_gen_next[2]),
    .o_rnd (w_rnd_a)
  );

  taus88_step u_step_b (
    .i_s0  (r_live[3]),
    .i_s1  (r_live[4]),
    .i_s2  (r_live[5]),
    .o_s0  (w_gen_next[3]),
    .o_s1  (w_gen_next[4]),
    .o_s2  (w_gen_next[5]),
    .o_rnd (w_rnd_b)
  );

  // Shadow write is folded in before the commit so a same-cycle write and
  // commit loads the freshly written word.
  always_comb begin
    w_shadow_next = r_shadow;
    for (int i = 0; i < 6; i++) begin
      if (bus.seed_we && (bus.seed_addr == 3'(i))) begin
        w_shadow_next[i] = bus.seed_data;
      end
    end
  end

  // Next-state / output logic. A commit overrides everything, including an
  // en=1 request in RUN, so no sample is produced on a commit cycle.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_live_next  = r_live;
    w_u0_next    = r_u0;
    w_u1_next    = r_u1;
    w_valid_next = 1'b0;

    if (bus.seed_commit) begin
      for (int i = 0; i < 6; i++) begin
        w_live_next[i] = fix_seed(w_shadow_next[i], seed_min(i), c_seed_def[i]);
      end
      w_cnt_next   = 8'd0;
      w_state_next = c_no_warmup ? ST_RUN : ST_WARMUP;
    end else begin
      case (r_state)
        ST_WARMUP: begin
          if (c_no_warmup) begin
            w_state_next = ST_RUN;
          end else begin
            w_live_next = w_gen_next;
            w_cnt_next  = r_cnt + 8'd1;
            if (r_cnt == c_warm_last) w_state_next = ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.en) begin
            w_live_next  = w_gen_next;
            w_u0_next    = {w_rnd_a, w_rnd_b[31:16]};
            w_u1_next    = w_rnd_b[15:0];
            w_valid_next = 1'b1;
          end
        end
        default: w_state_next = ST_WARMUP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_WARMUP;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= 8'd0;
      r_u0    <= 48'd0;
      r_u1    <= 16'd0;
      r_valid <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        r_live[i]   <= c_seed_def[i];
        r_shadow[i] <= c_seed_def[i];
      end
    end else begin
      r_cnt    <= w_cnt_next;
      r_u0     <= w_u0_next;
      r_u1     <= w_u1_next;
      r_valid  <= w_valid_next;
      r_live   <= w_live_next;
      r_shadow <= w_shadow_next;
    end
  end

  assign bus.u0    = r_u0;
  assign bus.u1    = r_u1;
  assign bus.valid = r_valid;
  assign bus.busy  = (r_state == ST_WARMUP);

endmodule
`default_nettype wire
